// File: rtl/mux_4to1_if.sv
// Bundles the lane data, select, hold and result signals of the 4-to-1 lane mux.
interface mux_4to1_if #(
   parameter int W = 1
);
   logic [4*W-1:0] MUX_in;
   logic [1:0]     MUX_sel;
   logic           hold;
   logic [W-1:0]   MUX_out;
   logic [W-1:0]   MUX_out_q;
   logic [1:0]     sel_q;
   logic           sel_chg;

   modport master (
      output MUX_in, MUX_sel, hold,
      input  MUX_out, MUX_out_q, sel_q, sel_chg
   );

   modport slave (
      input  MUX_in, MUX_sel, hold,
      output MUX_out, MUX_out_q, sel_q, sel_chg
   );
endinterface

// File: rtl/mux_4to1.sv
// 4-to-1 lane mux with a combinational result, a registered copy of the result
// and select, and a one-cycle pulse whenever the registered select changes.
module mux_4to1 #(
   parameter int W = 1
) (
   input logic       clk,
   input logic       rst,
   mux_4to1_if.slave bus
);

   function automatic logic [W-1:0] lane_pick(input logic [4*W-1:0] lanes,
                                              input logic [1:0]     sel);
      logic [W-1:0] res;
      case (sel)
         2'd0:    res = lanes[W-1:0];
         2'd1:    res = lanes[2*W-1:W];
         2'd2:    res = lanes[3*W-1:2*W];
         default: res = lanes[4*W-1:3*W];
      endcase
      return res;
   endfunction

   logic [W-1:0] out_p0;
   logic [W-1:0] out_q_p1;
   logic [1:0]   sel_p1;
   logic         chg_p1;

   assign out_p0 = lane_pick(bus.MUX_in, bus.MUX_sel);

   // p0 -> p1: register result and select; the change pulse compares against the
   // select held before this edge, so a reload of the same value never pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q_p1 <= '0;
         sel_p1   <= 2'd0;
         chg_p1   <= 1'b0;
      end else if (!bus.hold) begin
         out_q_p1 <= out_p0;
         sel_p1   <= bus.MUX_sel;
         chg_p1   <= (bus.MUX_sel != sel_p1);
      end else begin
         chg_p1   <= 1'b0;
      end
   end

   assign bus.MUX_out   = out_p0;
   assign bus.MUX_out_q = out_q_p1;
   assign bus.sel_q     = sel_p1;
   assign bus.sel_chg   = chg_p1;

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: a W=1 instance and a W=8 instance share clk/rst.
module tb_mux_4to1;

   logic clk;
   logic clk_en;
   logic rst;
   int   n_pass;
   int   n_total;

   mux_4to1_if #(.W(1)) if1 ();
   mux_4to1_if #(.W(8)) if8 ();

   mux_4to1 #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   mux_4to1 #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

   initial clk = 1'b0;
   always #5 if (clk_en) clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Exhaustive combinational check with the clock stopped.
   task automatic test_comb();
      logic [3:0] in_v;
      logic       exp;
      for (int i = 0; i < 16; i++) begin
         for (int s = 0; s < 4; s++) begin
            in_v = 4'(i);
            if1.MUX_in  = in_v;
            if1.MUX_sel = 2'(s);
            exp = in_v[s];
            #1;
            n_total++;
            if (if1.MUX_out !== exp) $display("FAIL comb in=%b sel=%0d: got %b want %b", in_v, s, if1.MUX_out, exp);
            else n_pass++;
         end
      end
      if1.MUX_in = 4'b0100; if1.MUX_sel = 2'd2; #1;
      n_total++;
      if (if1.MUX_out !== 1'b1) $display("FAIL comb_example: got %b want 1", if1.MUX_out);
      else n_pass++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      if1.MUX_in = 4'b0000; if1.MUX_sel = 2'd0; if1.hold = 1'b0;
      if8.MUX_in = 32'h0;   if8.MUX_sel = 2'd0; if8.hold = 1'b0;
      tick();
      n_total++; if (if1.MUX_out_q !== 1'b0) $display("FAIL reset_out_q: got %b want 0", if1.MUX_out_q); else n_pass++;
      n_total++; if (if1.sel_q !== 2'd0) $display("FAIL reset_sel_q: got %0d want 0", if1.sel_q); else n_pass++;
      n_total++; if (if1.sel_chg !== 1'b0) $display("FAIL reset_sel_chg: got %b want 0", if1.sel_chg); else n_pass++;
      n_total++; if (if8.MUX_out_q !== 8'h00) $display("FAIL reset_out_q8: got %h want 00", if8.MUX_out_q); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_latency();
      @(negedge clk);
      if1.MUX_in = 4'b1000; if1.MUX_sel = 2'd3;
      #1;
      n_total++; if (if1.MUX_out !== 1'b1) $display("FAIL lat_comb: got %b want 1", if1.MUX_out); else n_pass++;
      n_total++; if (if1.MUX_out_q !== 1'b0) $display("FAIL lat_pre_out_q: got %b want 0", if1.MUX_out_q); else n_pass++;
      tick();
      n_total++; if (if1.MUX_out_q !== 1'b1) $display("FAIL lat_out_q: got %b want 1", if1.MUX_out_q); else n_pass++;
      n_total++; if (if1.sel_q !== 2'd3) $display("FAIL lat_sel_q: got %0d want 3", if1.sel_q); else n_pass++;
      n_total++; if (if1.sel_chg !== 1'b1) $display("FAIL lat_chg_pulse: got %b want 1", if1.sel_chg); else n_pass++;
      tick();
      n_total++; if (if1.sel_chg !== 1'b0) $display("FAIL lat_chg_end: got %b want 0", if1.sel_chg); else n_pass++;
   endtask

   task automatic test_hold();
      @(negedge clk);
      if1.hold = 1'b1; if1.MUX_sel = 2'd0; if1.MUX_in = 4'b0000;
      #1;
      n_total++; if (if1.MUX_out !== 1'b0) $display("FAIL hold_comb: got %b want 0", if1.MUX_out); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_total++; if (if1.MUX_out_q !== 1'b1) $display("FAIL hold_out_q[%0d]: got %b want 1", k, if1.MUX_out_q); else n_pass++;
         n_total++; if (if1.sel_q !== 2'd3) $display("FAIL hold_sel_q[%0d]: got %0d want 3", k, if1.sel_q); else n_pass++;
         n_total++; if (if1.sel_chg !== 1'b0) $display("FAIL hold_chg[%0d]: got %b want 0", k, if1.sel_chg); else n_pass++;
      end
      @(negedge clk);
      if1.hold = 1'b0;
      tick();
      n_total++; if (if1.MUX_out_q !== 1'b0) $display("FAIL unhold_out_q: got %b want 0", if1.MUX_out_q); else n_pass++;
      n_total++; if (if1.sel_q !== 2'd0) $display("FAIL unhold_sel_q: got %0d want 0", if1.sel_q); else n_pass++;
      n_total++; if (if1.sel_chg !== 1'b1) $display("FAIL unhold_chg: got %b want 1", if1.sel_chg); else n_pass++;
   endtask

   task automatic test_rst_prio();
      @(negedge clk);
      if1.MUX_in = 4'b0100; if1.MUX_sel = 2'd2;
      tick();
      n_total++; if (if1.MUX_out_q !== 1'b1 || if1.sel_q !== 2'd2) $display("FAIL prio_setup: got q=%b sel=%0d want q=1 sel=2", if1.MUX_out_q, if1.sel_q); else n_pass++;
      @(negedge clk);
      rst = 1'b1; if1.hold = 1'b1;
      tick();
      n_total++; if (if1.MUX_out_q !== 1'b0) $display("FAIL prio_out_q: got %b want 0", if1.MUX_out_q); else n_pass++;
      n_total++; if (if1.sel_q !== 2'd0) $display("FAIL prio_sel_q: got %0d want 0", if1.sel_q); else n_pass++;
      n_total++; if (if1.sel_chg !== 1'b0) $display("FAIL prio_chg: got %b want 0", if1.sel_chg); else n_pass++;
      n_total++; if (if1.MUX_out !== 1'b1) $display("FAIL prio_comb: got %b want 1", if1.MUX_out); else n_pass++;
      // First unheld load after reset with select 0 must not pulse.
      @(negedge clk);
      rst = 1'b0; if1.hold = 1'b0; if1.MUX_sel = 2'd0; if1.MUX_in = 4'b0001;
      tick();
      n_total++; if (if1.sel_chg !== 1'b0) $display("FAIL post_rst_sel0_chg: got %b want 0", if1.sel_chg); else n_pass++;
      n_total++; if (if1.MUX_out_q !== 1'b1) $display("FAIL post_rst_out_q: got %b want 1", if1.MUX_out_q); else n_pass++;
   endtask

   task automatic test_wide();
      logic [1:0] sels [5];
      logic [7:0] exp_out [5];
      logic       exp_chg [5];
      sels    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      exp_out = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hDD};
      exp_chg = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      // Preload select 3 so the first load of 0 is a real change.
      @(negedge clk);
      if8.MUX_in = 32'hDDCCBBAA; if8.MUX_sel = 2'd3;
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if8.MUX_sel = sels[k];
         #1;
         n_total++; if (if8.MUX_out !== exp_out[k]) $display("FAIL wide_comb[%0d]: got %h want %h", k, if8.MUX_out, exp_out[k]); else n_pass++;
         tick();
         n_total++; if (if8.MUX_out_q !== exp_out[k]) $display("FAIL wide_out_q[%0d]: got %h want %h", k, if8.MUX_out_q, exp_out[k]); else n_pass++;
         n_total++; if (if8.sel_q !== sels[k]) $display("FAIL wide_sel_q[%0d]: got %0d want %0d", k, if8.sel_q, sels[k]); else n_pass++;
         n_total++; if (if8.sel_chg !== exp_chg[k]) $display("FAIL wide_chg[%0d]: got %b want %b", k, if8.sel_chg, exp_chg[k]); else n_pass++;
      end
   endtask

   task automatic test_isolation();
      @(negedge clk);
      if8.MUX_sel = 2'd1; if8.MUX_in = 32'h11225A33;
      tick();
      n_total++; if (if8.sel_chg !== 1'b1) $display("FAIL iso_entry_chg: got %b want 1", if8.sel_chg); else n_pass++;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if8.MUX_in = {8'($urandom), 8'($urandom), 8'h5A, 8'($urandom)};
         #1;
         n_total++; if (if8.MUX_out !== 8'h5A) $display("FAIL iso_comb[%0d]: got %h want 5a", k, if8.MUX_out); else n_pass++;
         tick();
         n_total++; if (if8.MUX_out_q !== 8'h5A) $display("FAIL iso_out_q[%0d]: got %h want 5a", k, if8.MUX_out_q); else n_pass++;
         n_total++; if (if8.sel_chg !== 1'b0) $display("FAIL iso_chg[%0d]: got %b want 0", k, if8.sel_chg); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] lane2 [4];
      lane2 = '{8'h01, 8'h80, 8'hFF, 8'h3C};
      // Select and data change on the same edge: the new lane's data is registered.
      @(negedge clk);
      if8.MUX_sel = 2'd2; if8.MUX_in = 32'h00_01_5A_00;
      tick();
      n_total++; if (if8.MUX_out_q !== 8'h01) $display("FAIL b2b_switch_out_q: got %h want 01", if8.MUX_out_q); else n_pass++;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         if8.MUX_in = {8'h00, lane2[k], 8'h5A, 8'h00};
         tick();
         n_total++; if (if8.MUX_out_q !== lane2[k]) $display("FAIL b2b_track[%0d]: got %h want %h", k, if8.MUX_out_q, lane2[k]); else n_pass++;
         n_total++; if (if8.sel_chg !== 1'b0) $display("FAIL b2b_chg[%0d]: got %b want 0", k, if8.sel_chg); else n_pass++;
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      clk_en = 1'b0; rst = 1'b0;
      if1.MUX_in = '0; if1.MUX_sel = 2'd0; if1.hold = 1'b0;
      if8.MUX_in = '0; if8.MUX_sel = 2'd0; if8.hold = 1'b0;
      test_comb();
      clk_en = 1'b1;
      test_reset();
      test_latency();
      test_hold();
      test_rst_prio();
      test_wide();
      test_isolation();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
